// File: rtl/pmod_pattern_gen.sv
// pmod_pattern_gen: programmable-rate pattern generator for PMOD pins.
// A prescaler produces a one-cycle tick every max(div_val,1) enabled cycles;
// each tick advances the selected pattern (binary count, walking one, bounce).
// PWM mode instead compares a free-running en-gated counter against duty.
// Optional build macro PMOD_PATTERN_GRAY_EN: COUNT mode outputs Gray code.
module pmod_pattern_gen #(
  parameter int OUT_W = 4,
  parameter int DIV_W = 24,
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic [PWM_W-1:0] duty,
  output logic [OUT_W-1:0] pmod_out,
  output logic             tick
);

  localparam logic [1:0] MODE_COUNT  = 2'd0;
  localparam logic [1:0] MODE_WALK   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_PWM    = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [DIV_W-1:0] pre_cnt_reg;
  logic [PWM_W-1:0] pwm_cnt_reg;
  logic [OUT_W-1:0] pattern_reg;
  logic [1:0]       mode_reg;
  logic             dir_reg;

  logic [DIV_W-1:0] div_eff;
  logic             term;
  logic [OUT_W-1:0] step_pattern;
  logic             step_dir;
  logic [OUT_W-1:0] pattern_next;
  logic             dir_next;
  logic [OUT_W-1:0] count_view;
  logic             pwm_level;
  logic [OUT_W-1:0] pwm_bits;
  logic [OUT_W-1:0] out_next;

  // Starting pattern for a mode: one-hot bit0 for the moving-dot modes, else 0.
  function automatic logic [OUT_W-1:0] init_pattern(input logic [1:0] m);
    if (m == MODE_WALK || m == MODE_BOUNCE) begin
      return OUT_W'(1);
    end
    return '0;
  endfunction

  // A divisor of 0 behaves as 1; >= compare keeps a mid-count shrink safe.
  assign div_eff = (div_val == '0) ? DIV_W'(1) : div_val;
  assign term    = en && (pre_cnt_reg >= (div_eff - DIV_W'(1)));

  assign pwm_level = (pwm_cnt_reg < duty);

  // Every PMOD bit carries the same PWM level.
  generate
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pwm_bits
      assign pwm_bits[gi] = pwm_level;
    end
  endgenerate

  // Next pattern value for one tick in the current mode.
  always_comb begin
    step_pattern = pattern_reg;
    step_dir     = dir_reg;
    case (mode_reg)
      MODE_COUNT: step_pattern = pattern_reg + OUT_W'(1);
      MODE_WALK:  step_pattern = (pattern_reg << 1) | (pattern_reg >> (OUT_W - 1));
      MODE_BOUNCE: begin
        if (OUT_W == 1) begin
          step_pattern = OUT_W'(1);
        end else if (dir_reg == DIR_LEFT) begin
          if (pattern_reg[OUT_W-1]) begin
            step_pattern = pattern_reg >> 1;
            step_dir     = DIR_RIGHT;
          end else begin
            step_pattern = pattern_reg << 1;
          end
        end else begin
          if (pattern_reg[0]) begin
            step_pattern = pattern_reg << 1;
            step_dir     = DIR_LEFT;
          end else begin
            step_pattern = pattern_reg >> 1;
          end
        end
      end
      default: step_pattern = pattern_reg;
    endcase
  end

  // Pattern after this edge, and the value presented on the pins for it.
  always_comb begin
    pattern_next = term ? step_pattern : pattern_reg;
    dir_next     = term ? step_dir : dir_reg;
`ifdef PMOD_PATTERN_GRAY_EN
    count_view   = pattern_next ^ (pattern_next >> 1);
`else
    count_view   = pattern_next;
`endif
    case (mode_reg)
      MODE_COUNT: out_next = count_view;
      MODE_PWM:   out_next = pwm_bits;
      default:    out_next = pattern_next;
    endcase
  end

  // State update: reset, then mode change, then enabled prescaler/pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_reg <= '0;
      pwm_cnt_reg <= '0;
      tick        <= 1'b0;
      pmod_out    <= '0;
      dir_reg     <= DIR_LEFT;
      mode_reg    <= mode;
      pattern_reg <= init_pattern(mode);
    end else if (mode != mode_reg) begin
      pre_cnt_reg <= '0;
      pwm_cnt_reg <= '0;
      tick        <= 1'b0;
      dir_reg     <= DIR_LEFT;
      mode_reg    <= mode;
      pattern_reg <= init_pattern(mode);
      pmod_out    <= init_pattern(mode);
    end else if (en) begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
      pattern_reg <= pattern_next;
      dir_reg     <= dir_next;
      pmod_out    <= out_next;
      if (term) begin
        pre_cnt_reg <= '0;
        tick        <= 1'b1;
      end else begin
        pre_cnt_reg <= pre_cnt_reg + DIV_W'(1);
        tick        <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pmod_pattern_gen.sv
// Testbench for pmod_pattern_gen: directed test-plan scenarios followed by
// randomized segments, every cycle compared against a tick-index based model.
module tb_pmod_pattern_gen;

  localparam int OUT_W = 4;
  localparam int DIV_W = 24;
  localparam int PWM_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div_val;
  logic [PWM_W-1:0] duty;
  logic [OUT_W-1:0] pmod_out;
  logic             tick;

  pmod_pattern_gen #(.OUT_W(OUT_W), .DIV_W(DIV_W), .PWM_W(PWM_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div_val(div_val),
    .duty(duty), .pmod_out(pmod_out), .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: ticks taken (k) and enabled cycles (n) since last restart.
  int m_mode, m_phase, m_k, m_n, m_pmod, m_tick;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pattern_view(input int md, input int k);
    int c, t;
    case (md)
      0: begin
        c = k % (1 << OUT_W);
`ifdef PMOD_PATTERN_GRAY_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
      end
      1: return 1 << (k % OUT_W);
      default: begin
        t = k % (2 * OUT_W - 2);
        return 1 << ((t < OUT_W) ? t : (2 * OUT_W - 2 - t));
      end
    endcase
  endfunction

  task automatic model_edge();
    int d;
    d = (div_val == 0) ? 1 : int'(div_val);
    if (!rst_n) begin
      m_mode = mode; m_phase = 0; m_k = 0; m_n = 0; m_pmod = 0; m_tick = 0;
    end else if (int'(mode) != m_mode) begin
      m_mode = mode; m_phase = 0; m_k = 0; m_n = 0; m_tick = 0;
      m_pmod = (m_mode == 1 || m_mode == 2) ? 1 : 0;
    end else if (en) begin
      if (m_phase + 1 >= d) begin
        m_phase = 0; m_k++; m_tick = 1;
      end else begin
        m_phase++; m_tick = 0;
      end
      if (m_mode == 3) m_pmod = ((m_n % (1 << PWM_W)) < int'(duty)) ? (1 << OUT_W) - 1 : 0;
      else             m_pmod = pattern_view(m_mode, m_k);
      m_n++;
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("pmod_out", int'(pmod_out), m_pmod);
    check_val("tick", int'(tick), m_tick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_pmod(input int target, input int limit);
    int i;
    i = 0;
    while (int'(pmod_out) != target && i < limit) begin
      step();
      i++;
    end
    check_val("reach_value", int'(pmod_out), target);
  endtask

  task automatic count_high(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (pmod_out[0]) highs++;
    end
  endtask

  initial begin
    int highs, seg_len;
    rst_n = 1'b0; en = 1'b1; mode = 2'd0; div_val = 3; duty = 0;
    step();
    $display("reset: pmod_out=%0d tick=%0d", pmod_out, tick);
    rst_n = 1'b1;
    run(60);
    $display("count div=3: pmod_out=%0d", pmod_out);

    mode = 2'd1; div_val = 1;
    run(10);
    $display("walk div=1: pmod_out=%0d", pmod_out);

    mode = 2'd2; div_val = 0;
    run(14);
    $display("bounce div=0: pmod_out=%0d", pmod_out);

    mode = 2'd3; duty = 64; div_val = 5;
    step();
    count_high(256, highs);
    check_val("pwm_duty64_highs", highs, 64);
    $display("pwm duty=64: highs=%0d", highs);
    duty = 0;
    count_high(512, highs);
    check_val("pwm_duty0_highs", highs, 0);
    $display("pwm duty=0: highs=%0d", highs);
    duty = 255;
    count_high(256, highs);
    check_val("pwm_duty255_highs", highs, 255);
    $display("pwm duty=255: highs=%0d", highs);

    mode = 2'd0; div_val = 2;
    run_until_pmod(5, 100);
    en = 1'b0;
    run(10);
    check_val("hold_value", int'(pmod_out), 5);
    en = 1'b1;
    run(2);
    check_val("resume_value", int'(pmod_out), pattern_view(0, 6));
    $display("en hold: pmod_out=%0d", pmod_out);

    run_until_pmod(pattern_view(0, 9), 100);
    mode = 2'd1;
    step();
    check_val("switch_walk", int'(pmod_out), 1);
    run(5);
    $display("mode switch: pmod_out=%0d", pmod_out);

    rst_n = 1'b0;
    step();
    check_val("midrun_reset", int'(pmod_out), 0);
    rst_n = 1'b1;
    $display("mid-run reset: pmod_out=%0d tick=%0d", pmod_out, tick);

    for (int s = 0; s < 40; s++) begin
      mode = 2'($urandom_range(0, 3));
      div_val = DIV_W'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: duty = 0;
        1: duty = 255;
        default: duty = PWM_W'($urandom_range(0, 255));
      endcase
      seg_len = $urandom_range(20, 80);
      for (int c = 0; c < seg_len; c++) begin
        en = ($urandom_range(0, 9) != 0);
        rst_n = ($urandom_range(0, 199) != 0);
        if ($urandom_range(0, 29) == 0) div_val = DIV_W'($urandom_range(0, 5));
        step();
      end
      rst_n = 1'b1;
      $display("segment %0d: mode=%0d div=%0d duty=%0d len=%0d", s, mode, div_val, duty, seg_len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
